interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller_pkg.sv | 20 ++
 rtl/interrupt_controller_if.sv | 29 ++
 rtl/intc_prio_enc.sv | 23 ++
 rtl/interrupt_controller.sv | 96 +++++++++
 tb/tb_interrupt_controller.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared constants and types for the interrupt controller: source map,
// cause index width and the request/service FSM state encoding.
package interrupt_controller_pkg;

  localparam int NSRC  = 5;
  localparam int IDX_W = 3;

  localparam logic [IDX_W-1:0] SRC_SW    = 3'd0;
  localparam logic [IDX_W-1:0] SRC_TIMER = 3'd1;
  localparam logic [IDX_W-1:0] SRC_IO0   = 3'd2;
  localparam logic [IDX_W-1:0] SRC_IO1   = 3'd3;
  localparam logic [IDX_W-1:0] SRC_IO2   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/interrupt_controller_if.sv
// CPU/source-facing signal bundle of the interrupt controller; the master side
// raises requests and handshakes, the slave side is the controller itself.
interface interrupt_controller_if #(
  parameter int NSRC = interrupt_controller_pkg::NSRC
);

  logic            sw_int;
  logic            timer_int;
  logic [2:0]      io_int;
  logic            int_enable;
  logic [NSRC-1:0] mask;
  logic            ack;
  logic            eoi;
  logic            irq;
  logic [2:0]      cause;
  logic            timer_stop;
  logic            timer_reset;

  modport master (
    output sw_int, timer_int, io_int, int_enable, mask, ack, eoi,
    input  irq, cause, timer_stop, timer_reset
  );

  modport slave (
    input  sw_int, timer_int, io_int, int_enable, mask, ack, eoi,
    output irq, cause, timer_stop, timer_reset
  );

endinterface

// File: rtl/intc_prio_enc.sv
// Fixed-priority encoder: returns the lowest set bit index and a valid flag.
module intc_prio_enc #(
  parameter int NSRC  = interrupt_controller_pkg::NSRC,
  parameter int IDX_W = interrupt_controller_pkg::IDX_W
) (
  input  logic [NSRC-1:0]  i_req,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Scan downward so the last hit, the lowest index, is what remains.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = IDX_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Non-preemptive interrupt controller: latches source pulses, presents the
// highest-priority enabled one to the CPU and freezes the quantum timer meanwhile.
module interrupt_controller #(
  parameter int NSRC            = interrupt_controller_pkg::NSRC,
  parameter bit RESTART_QUANTUM = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  interrupt_controller_if.slave  bus
);

  import interrupt_controller_pkg::*;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NSRC-1:0]  r_pending;
  logic [NSRC-1:0]  w_req;
  logic [NSRC-1:0]  w_clr;
  logic [NSRC-1:0]  w_active;
  logic [IDX_W-1:0] r_cause;
  logic [IDX_W-1:0] w_enc_idx;
  logic             w_enc_vld;
  logic             w_load_cause;
  logic             w_take_ack;
  logic             w_take_eoi;
  logic             r_timer_reset;

  assign w_req    = {bus.io_int, bus.timer_int, bus.sw_int};
  assign w_active = r_pending & bus.mask;

  intc_prio_enc #(
    .NSRC  (NSRC),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .i_req   (w_active),
    .o_idx   (w_enc_idx),
    .o_valid (w_enc_vld)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // ack wins over a same-cycle enable drop; eoi in PRESENT is ignored.
  always_comb begin
    w_state_nxt  = r_state;
    w_load_cause = 1'b0;
    w_take_ack   = 1'b0;
    w_take_eoi   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.int_enable && w_enc_vld) begin
          w_state_nxt  = ST_PRESENT;
          w_load_cause = 1'b1;
        end
      end
      ST_PRESENT: begin
        if (bus.ack) begin
          w_state_nxt = ST_SERVICE;
          w_take_ack  = 1'b1;
        end else if (!bus.int_enable) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (bus.eoi) begin
          w_state_nxt = ST_IDLE;
          w_take_eoi  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_clr = w_take_ack ? (NSRC'(1) << r_cause) : '0;

  // Set is OR-ed after the clear so a request on the ack edge survives.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pending     <= '0;
      r_cause       <= '0;
      r_timer_reset <= 1'b0;
    end else begin
      r_pending     <= (r_pending & ~w_clr) | w_req;
      r_timer_reset <= w_take_eoi & RESTART_QUANTUM;
      if (w_load_cause) r_cause <= w_enc_idx;
    end
  end

  assign bus.irq         = (r_state == ST_PRESENT);
  assign bus.cause       = r_cause;
  assign bus.timer_stop  = (r_state != ST_IDLE);
  assign bus.timer_reset = r_timer_reset;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with hand-computed expectations.
module tb_interrupt_controller;

  logic clock;
  logic reset;
  int   n_total;
  int   n_bad;

  interrupt_controller_if bus ();

  interrupt_controller #(
    .NSRC            (5),
    .RESTART_QUANTUM (1'b1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    bus.sw_int    = 1'b0;
    bus.timer_int = 1'b0;
    bus.io_int    = 3'b000;
    bus.ack       = 1'b0;
    bus.eoi       = 1'b0;
  endtask

  task automatic outs(input string tag, input logic irq, input logic [2:0] cause,
                      input logic tstop, input logic treset);
    chk({tag, ".irq"},   32'(bus.irq),         32'(irq));
    chk({tag, ".cause"}, 32'(bus.cause),       32'(cause));
    chk({tag, ".tstop"}, 32'(bus.timer_stop),  32'(tstop));
    chk({tag, ".trst"},  32'(bus.timer_reset), 32'(treset));
  endtask

  task automatic pend(input string tag, input logic [4:0] exp);
    chk({tag, ".pend"}, 32'(dut.r_pending), 32'(exp));
  endtask

  // ack then eoi for the interrupt presently shown, leaving state IDLE
  task automatic finish_irq();
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    quiet();
    bus.int_enable = 1'b1;
    bus.mask       = 5'b11111;
    reset          = 1'b1;

    // reset, with a same-cycle request that must not latch
    bus.sw_int = 1'b1;
    tick();
    bus.sw_int = 1'b0;
    tick();
    outs("rst", 1'b0, 3'd0, 1'b0, 1'b0);
    pend("rst", 5'b00000);
    reset = 1'b0;

    // ack and eoi in IDLE are ignored
    bus.ack = 1'b1; bus.eoi = 1'b1; tick(); quiet();
    outs("idle_ign", 1'b0, 3'd0, 1'b0, 1'b0);

    // timer request: latency, ack clears pending, eoi pulses timer_reset
    bus.timer_int = 1'b1; tick(); bus.timer_int = 1'b0;
    outs("tm_n", 1'b0, 3'd0, 1'b0, 1'b0);
    pend("tm_n", 5'b00010);
    tick();
    outs("tm_n1", 1'b1, 3'd1, 1'b1, 1'b0);
    tick(); tick();
    outs("tm_hold", 1'b1, 3'd1, 1'b1, 1'b0);
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    outs("tm_ack", 1'b0, 3'd1, 1'b1, 1'b0);
    pend("tm_ack", 5'b00000);
    tick();
    outs("tm_svc", 1'b0, 3'd1, 1'b1, 1'b0);
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    outs("tm_eoi", 1'b0, 3'd1, 1'b0, 1'b1);
    tick();
    outs("tm_post", 1'b0, 3'd1, 1'b0, 1'b0);

    // eoi in IDLE gives no pulse
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    outs("eoi_idle", 1'b0, 3'd1, 1'b0, 1'b0);

    // sw and io2 together: 0 first, then 4 back-to-back; ack+eoi acts as ack
    bus.sw_int = 1'b1; bus.io_int = 3'b100; tick(); quiet();
    pend("two_set", 5'b10001);
    tick();
    outs("two_c0", 1'b1, 3'd0, 1'b1, 1'b0);
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    pend("two_ack0", 5'b10000);
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    outs("two_eoi0", 1'b0, 3'd0, 1'b0, 1'b1);
    tick();
    outs("two_c4", 1'b1, 3'd4, 1'b1, 1'b0);
    bus.ack = 1'b1; bus.eoi = 1'b1; tick(); quiet();
    outs("two_ackeoi", 1'b0, 3'd4, 1'b1, 1'b0);
    pend("two_ackeoi", 5'b00000);
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    outs("two_eoi4", 1'b0, 3'd4, 1'b0, 1'b1);
    tick();
    outs("two_post", 1'b0, 3'd4, 1'b0, 1'b0);

    // masked timer source stays pending until unmasked
    bus.mask = 5'b11101;
    bus.timer_int = 1'b1; tick(); bus.timer_int = 1'b0;
    tick(); tick();
    outs("msk_off", 1'b0, 3'd4, 1'b0, 1'b0);
    pend("msk_off", 5'b00010);
    bus.mask = 5'b11111; tick();
    outs("msk_on", 1'b1, 3'd1, 1'b1, 1'b0);
    finish_irq(); tick();

    // enable drop in PRESENT returns to IDLE, pending kept, re-presented
    bus.io_int = 3'b010; tick(); bus.io_int = 3'b000;
    tick();
    outs("en_c3", 1'b1, 3'd3, 1'b1, 1'b0);
    bus.int_enable = 1'b0; tick();
    outs("en_drop", 1'b0, 3'd3, 1'b0, 1'b0);
    pend("en_drop", 5'b01000);
    tick();
    outs("en_off", 1'b0, 3'd3, 1'b0, 1'b0);
    bus.int_enable = 1'b1; tick();
    outs("en_back", 1'b1, 3'd3, 1'b1, 1'b0);
    finish_irq(); tick();

    // no preemption: sw request while cause 2 is presented
    bus.io_int = 3'b001; tick(); bus.io_int = 3'b000;
    tick();
    outs("np_c2", 1'b1, 3'd2, 1'b1, 1'b0);
    bus.sw_int = 1'b1; tick(); bus.sw_int = 1'b0;
    tick();
    outs("np_hold", 1'b1, 3'd2, 1'b1, 1'b0);
    pend("np_hold", 5'b00101);
    finish_irq(); tick();
    outs("np_c0", 1'b1, 3'd0, 1'b1, 1'b0);
    finish_irq(); tick();
    pend("np_done", 5'b00000);

    // timer request on its own ack edge: set wins, re-presented after eoi
    bus.timer_int = 1'b1; tick(); bus.timer_int = 1'b0;
    tick();
    outs("sw_c1", 1'b1, 3'd1, 1'b1, 1'b0);
    bus.ack = 1'b1; bus.timer_int = 1'b1; tick(); quiet();
    outs("sw_ack", 1'b0, 3'd1, 1'b1, 1'b0);
    pend("sw_ack", 5'b00010);
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    tick();
    outs("sw_again", 1'b1, 3'd1, 1'b1, 1'b0);

    // reset in SERVICE with pending 10110 abandons everything
    bus.ack = 1'b1; bus.timer_int = 1'b1; bus.io_int = 3'b101; tick(); quiet();
    pend("rs_svc", 5'b10110);
    outs("rs_svc", 1'b0, 3'd1, 1'b1, 1'b0);
    reset = 1'b1; bus.eoi = 1'b1; tick(); quiet();
    outs("rs_now", 1'b0, 3'd0, 1'b0, 1'b0);
    pend("rs_now", 5'b00000);
    reset = 1'b0; tick();
    outs("rs_after", 1'b0, 3'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
